// File: rtl/config_register_file.sv
// Config register file: a bank of NUM_REGS word-wide registers written through a
// strobe-only write channel and read through a one-entry, backpressurable response
// register. Register contents and per-register update pulses are exported directly.
module config_register_file #(
  parameter int                          AXI_ADDR_BITS   = 32,
  parameter int                          AXIL_DATA_BITS  = 32,
  parameter int                          NUM_REGS        = 16,
  parameter logic [AXI_ADDR_BITS-1:0]    BASE_ADDR       = '0,
  parameter logic [AXIL_DATA_BITS-1:0]   REG_RESET_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [AXI_ADDR_BITS-1:0]           wr_addr,
  input  logic [AXIL_DATA_BITS-1:0]          wr_data,
  input  logic                               wr_valid,
  input  logic [AXI_ADDR_BITS-1:0]           rd_addr,
  input  logic                               rd_valid,
  output logic                               rd_ready,
  output logic [AXIL_DATA_BITS-1:0]          resp_data,
  output logic                               resp_error,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [NUM_REGS*AXIL_DATA_BITS-1:0] reg_q,
  output logic [NUM_REGS-1:0]                reg_update,
  output logic                               wr_drop
);

  localparam int W         = AXIL_DATA_BITS;
  localparam int BPW       = W / 8;
  localparam int OFFS_BITS = $clog2(BPW);
  localparam int IDX_BITS  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit so that an address below BASE_ADDR shows up as negative
  // instead of wrapping into the register window.
  localparam int DW        = AXI_ADDR_BITS + 1;

  // Address is a hit when it lies at or above the base, is word aligned and
  // falls inside the register window.
  function automatic logic addr_hit(input logic [AXI_ADDR_BITS-1:0] a);
    logic [DW-1:0] diff;
    logic [DW-1:0] word;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    word = diff >> OFFS_BITS;
    return !diff[DW-1] && ((word << OFFS_BITS) == diff) && (word < DW'(NUM_REGS));
  endfunction

  // Register index of an address; only meaningful when addr_hit() is true.
  function automatic logic [IDX_BITS-1:0] addr_idx(input logic [AXI_ADDR_BITS-1:0] a);
    logic [DW-1:0] diff;
    logic [DW-1:0] word;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    word = diff >> OFFS_BITS;
    return IDX_BITS'(word);
  endfunction

  logic                wr_hit;
  logic [IDX_BITS-1:0] wr_idx;
  logic                rd_hit;
  logic [IDX_BITS-1:0] rd_idx;
  logic                rd_accept;
  logic [W-1:0]        regs_view [NUM_REGS];
  logic [W-1:0]        rd_word;

  logic                resp_valid_reg;
  logic                resp_error_reg;
  logic [W-1:0]        resp_data_reg;
  logic                wr_drop_reg;

  // Address decode for both channels.
  always_comb begin
    wr_hit = addr_hit(wr_addr);
    wr_idx = addr_idx(wr_addr);
    rd_hit = addr_hit(rd_addr);
    rd_idx = addr_idx(rd_addr);
  end

  // A new read may enter whenever the response slot is empty or being drained.
  assign rd_ready  = !resp_valid_reg || resp_ready;
  assign rd_accept = rd_valid && rd_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic         wr_sel;
      logic [W-1:0] value_reg;
      logic         update_reg;

      assign wr_sel = wr_valid && wr_hit && (wr_idx == IDX_BITS'(gi));

      // Register storage and its one-cycle update pulse.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          value_reg  <= REG_RESET_VALUE;
          update_reg <= 1'b0;
        end else begin
          if (wr_sel) begin
            value_reg <= wr_data;
          end
          update_reg <= wr_sel;
        end
      end

      assign regs_view[gi]        = value_reg;
      assign reg_q[gi*W +: W]     = value_reg;
      assign reg_update[gi]       = update_reg;
    end
  endgenerate

  // Read source uses the pre-edge register value, so a same-cycle write is not seen.
  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      rd_word = regs_view[rd_idx];
    end
  end

  // Flag writes that decoded to no register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_drop_reg <= 1'b0;
    end else begin
      wr_drop_reg <= wr_valid && !wr_hit;
    end
  end

  // One-entry response slot: load on accept, hold while stalled, empty when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_error_reg <= 1'b0;
      resp_data_reg  <= '0;
    end else if (rd_accept) begin
      resp_valid_reg <= 1'b1;
      resp_error_reg <= !rd_hit;
      resp_data_reg  <= rd_word;
    end else if (resp_ready) begin
      resp_valid_reg <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_error = resp_error_reg;
  assign resp_data  = resp_data_reg;
  assign wr_drop    = wr_drop_reg;

endmodule

// File: tb/tb_config_register_file.sv
// Directed and randomized checks of the config register file: decode boundaries,
// update/drop pulses, read latency, backpressure, read-during-write and async reset.
module tb_config_register_file;

  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] RV   = 32'h0000_1234;

  logic             clk;
  logic             rst;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             wr_valid;
  logic [31:0]      rd_addr;
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      resp_data;
  logic             resp_error;
  logic             resp_valid;
  logic             resp_ready;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0]    reg_update;
  logic             wr_drop;

  int passed;
  int total;
  logic [31:0] model [NR];

  config_register_file #(
    .AXI_ADDR_BITS  (32),
    .AXIL_DATA_BITS (32),
    .NUM_REGS       (NR),
    .BASE_ADDR      (BASE),
    .REG_RESET_VALUE(RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .resp_data (resp_data),
    .resp_error(resp_error),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .reg_q     (reg_q),
    .reg_update(reg_update),
    .wr_drop   (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    bit          exp_err;
    bit          exp_drop;
    logic [15:0] exp_upd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit tb_valid(input logic [31:0] a);
    logic [31:0] t;
    t = a;
    return (t >= 32'h100) && (t < 32'h140) && (t[1:0] == 2'b00);
  endfunction

  function automatic int tb_idx(input logic [31:0] a);
    return int'((a - 32'h100) >> 2);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1, 2: a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      3:       a = 32'h140 + 32'($urandom_range(0, 3)) * 4;
      4:       a = 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      default: a = 32'($urandom_range(0, 63)) * 4;
    endcase
    return a;
  endfunction

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s reg_q[%0d]", tag, i), {32'h0, reg_q[i*32 +: 32]}, {32'h0, model[i]});
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1; wr_addr = '0; wr_data = '0; wr_valid = 1'b0;
    rd_addr = '0; rd_valid = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = RV;

    //                 wr    addr          data          exp_data      err drop upd
    vecs[0]  = '{1'b0, 32'h0000_010C, 32'h0,        RV,           1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0,       1'b0, 1'b0, 16'h0004};
    vecs[2]  = '{1'b0, 32'h0000_0108, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 32'h0000_0140, 32'h0,        32'h0,        1'b1, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 32'h0000_00FC, 32'h0,        32'h0,        1'b1, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 32'h0000_0140, 32'h1111_1111, 32'h0,       1'b0, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 32'h0000_0101, 32'h2222_2222, 32'h0,       1'b0, 1'b1, 16'h0000};
    vecs[8]  = '{1'b1, 32'h0000_00FC, 32'h3333_3333, 32'h0,       1'b0, 1'b1, 16'h0000};
    vecs[9]  = '{1'b1, 32'h0000_013C, 32'h1234_5678, 32'h0,       1'b0, 1'b0, 16'h8000};
    vecs[10] = '{1'b0, 32'h0000_013C, 32'h0,        32'h1234_5678, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 32'h0000_0100, 32'h0,        RV,           1'b0, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1'b0, 16'h0000};
    vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,        1'b1, 1'b0, 16'h0000};
    vecs[14] = '{1'b1, 32'hFFFF_FFFC, 32'h4444_4444, 32'h0,       1'b0, 1'b1, 16'h0000};

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("reset resp_valid", {63'h0, resp_valid}, 64'h0);
    chk("reset rd_ready", {63'h0, rd_ready}, 64'h1);
    chk("reset reg_update", {48'h0, reg_update}, 64'h0);
    chk("reset wr_drop", {63'h0, wr_drop}, 64'h0);
    check_all_regs("reset");

    // Table-driven single transactions
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].is_wr) begin
        wr_addr = vecs[v].addr; wr_data = vecs[v].data; wr_valid = 1'b1;
        if (tb_valid(vecs[v].addr)) model[tb_idx(vecs[v].addr)] = vecs[v].data;
      end else begin
        rd_addr = vecs[v].addr; rd_valid = 1'b1;
      end
      step();
      wr_valid = 1'b0; rd_valid = 1'b0;
      if (vecs[v].is_wr) begin
        chk($sformatf("vec%0d reg_update", v), {48'h0, reg_update}, {48'h0, vecs[v].exp_upd});
        chk($sformatf("vec%0d wr_drop", v), {63'h0, wr_drop}, {63'h0, vecs[v].exp_drop});
      end else begin
        chk($sformatf("vec%0d resp_valid", v), {63'h0, resp_valid}, 64'h1);
        chk($sformatf("vec%0d resp_data", v), {32'h0, resp_data}, {32'h0, vecs[v].exp_data});
        chk($sformatf("vec%0d resp_error", v), {63'h0, resp_error}, {63'h0, vecs[v].exp_err});
      end
    end
    step();
    chk("pulses clear reg_update", {48'h0, reg_update}, 64'h0);
    chk("pulses clear wr_drop", {63'h0, wr_drop}, 64'h0);
    chk("resp drained", {63'h0, resp_valid}, 64'h0);
    check_all_regs("after table");

    // Update pulse lasts exactly one cycle
    wr_addr = 32'h108; wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("upd pulse on", {48'h0, reg_update}, 64'h4);
    step();
    chk("upd pulse off", {48'h0, reg_update}, 64'h0);

    // Stalled response
    resp_ready = 1'b0; rd_addr = 32'h108; rd_valid = 1'b1;
    step();
    rd_addr = 32'h13C;
    wr_addr = 32'h108; wr_data = 32'h0000_0055; wr_valid = 1'b1;
    model[2] = 32'h0000_0055;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d rd_ready", k), {63'h0, rd_ready}, 64'h0);
      chk($sformatf("stall%0d resp_valid", k), {63'h0, resp_valid}, 64'h1);
      chk($sformatf("stall%0d resp_data", k), {32'h0, resp_data}, 64'hDEAD_BEEF);
      chk($sformatf("stall%0d resp_error", k), {63'h0, resp_error}, 64'h0);
      step();
      wr_valid = 1'b0;
    end
    resp_ready = 1'b1;
    #1;
    chk("release rd_ready", {63'h0, rd_ready}, 64'h1);
    step();
    chk("burst0 data", {32'h0, resp_data}, 64'h1234_5678);
    rd_addr = 32'h108;
    step();
    chk("burst1 valid", {63'h0, resp_valid}, 64'h1);
    chk("burst1 data", {32'h0, resp_data}, 64'h55);
    rd_addr = 32'h104;
    step();
    chk("burst2 valid", {63'h0, resp_valid}, 64'h1);
    chk("burst2 data", {32'h0, resp_data}, {32'h0, RV});
    rd_valid = 1'b0;
    step();
    chk("burst end valid", {63'h0, resp_valid}, 64'h0);

    // Same-cycle write and read of one register returns the old value
    wr_addr = 32'h100; wr_data = 32'h0; wr_valid = 1'b1;
    step();
    wr_data = 32'h1; rd_addr = 32'h100; rd_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("rdw old data", {32'h0, resp_data}, 64'h0);
    step();
    rd_valid = 1'b0;
    chk("rdw new data", {32'h0, resp_data}, 64'h1);
    model[0] = 32'h1;
    step();

    // Asynchronous reset during a stalled response
    resp_ready = 1'b0; rd_addr = 32'h104; rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    chk("pre-rst resp_valid", {63'h0, resp_valid}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst resp_valid", {63'h0, resp_valid}, 64'h0);
    chk("async rst resp_data", {32'h0, resp_data}, 64'h0);
    for (int i = 0; i < NR; i++) model[i] = RV;
    check_all_regs("async rst");
    step();
    rst = 1'b0; resp_ready = 1'b1;
    step();

    // Random traffic against a scoreboard
    for (int c = 0; c < 60; c++) begin
      bit          do_wr;
      bit          do_rd;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] ra;
      logic [31:0] exp_rd;
      bit          exp_err;
      do_wr = bit'($urandom_range(0, 1));
      do_rd = bit'($urandom_range(0, 1));
      wa = rand_addr(); wd = $urandom(); ra = rand_addr();
      exp_err = !tb_valid(ra);
      exp_rd  = exp_err ? 32'h0 : model[tb_idx(ra)];
      wr_addr = wa; wr_data = wd; wr_valid = do_wr;
      rd_addr = ra; rd_valid = do_rd;
      if (do_wr && tb_valid(wa)) model[tb_idx(wa)] = wd;
      step();
      wr_valid = 1'b0; rd_valid = 1'b0;
      chk($sformatf("rnd%0d resp_valid", c), {63'h0, resp_valid}, {63'h0, do_rd});
      if (do_rd) begin
        chk($sformatf("rnd%0d resp_data", c), {32'h0, resp_data}, {32'h0, exp_rd});
        chk($sformatf("rnd%0d resp_error", c), {63'h0, resp_error}, {63'h0, exp_err});
      end
      chk($sformatf("rnd%0d wr_drop", c), {63'h0, wr_drop}, {63'h0, do_wr && !tb_valid(wa)});
    end
    check_all_regs("random end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
